bsg_stream_len_framer: RTL and testbench

// - Frames a ready/valid word stream into length-delimited packets. Each packet
//   is one header word carrying a payload length N, followed by N payload words.
// - The block strips the header, forwards the payload unchanged and marks the

---
 rtl/bsg_stream_len_framer.sv | 110 +++++++++++
 tb/tb_bsg_stream_len_framer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_stream_len_framer.sv
// rtl/bsg_stream_len_framer.sv - length-delimited packet framer for a ready/valid word stream
//
// Each packet is one header word carrying payload length N, then N payload
// words. The header is consumed and the payload is passed through with
// last_o on its final word. len_o/beat_o feed a downstream beat counter.
//
// Optional build macro BSG_STREAM_LEN_FRAMER_FWD_HDR_EN: when defined, the
// header word is also emitted as an output beat (last_o set iff N==0).

module bsg_stream_len_framer #(
  parameter int width_p      = 32,
  parameter int len_width_p  = 8,
  parameter int len_offset_p = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [width_p-1:0]     data_o,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic [len_width_p-1:0] len_o,
  output logic [len_width_p-1:0] beat_o,
  output logic                   idle_o
);

  typedef enum logic {eHDR, ePAY} state_e;

  state_e                 state_r, state_n;
  logic [len_width_p-1:0] len_r, beat_r;
  logic [len_width_p-1:0] hdr_len;
  logic                   hdr_xfer, pay_xfer, last_beat;

  assign hdr_len = data_i[len_offset_p +: len_width_p];

  // Compare one bit wider so N = 2^len_width_p-1 cannot wrap into an early last.
  assign last_beat = ({1'b0, beat_r} + 1'b1) == {1'b0, len_r};

`ifdef BSG_STREAM_LEN_FRAMER_FWD_HDR_EN
  assign hdr_xfer = (state_r == eHDR) & v_i & ready_i;
`else
  assign hdr_xfer = (state_r == eHDR) & v_i;
`endif
  assign pay_xfer = (state_r == ePAY) & v_i & ready_i;

  // State, latched length and payload beat index.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eHDR;
      len_r   <= '0;
      beat_r  <= '0;
    end else begin
      state_r <= state_n;
      if (hdr_xfer) begin
        len_r  <= hdr_len;
        beat_r <= '0;
      end else if (pay_xfer) begin
        beat_r <= last_beat ? '0 : beat_r + 1'b1;
      end
    end
  end

  // Header with N==0 leaves us waiting for the next header.
  always_comb begin
    state_n = state_r;
    case (state_r)
      eHDR:    if (hdr_xfer && (hdr_len != '0)) state_n = ePAY;
      ePAY:    if (pay_xfer && last_beat)       state_n = eHDR;
      default: state_n = eHDR;
    endcase
  end

  // Handshake outputs; payload is a zero-latency pass-through.
  always_comb begin
    v_o     = 1'b0;
    ready_o = 1'b1;
    last_o  = 1'b0;
    case (state_r)
      eHDR: begin
`ifdef BSG_STREAM_LEN_FRAMER_FWD_HDR_EN
        v_o     = v_i;
        ready_o = ready_i;
        last_o  = v_i & (hdr_len == '0);
`else
        v_o     = 1'b0;
        ready_o = 1'b1;
        last_o  = 1'b0;
`endif
      end
      ePAY: begin
        v_o     = v_i;
        ready_o = ready_i;
        last_o  = v_i & last_beat;
      end
      default: begin
        v_o     = 1'b0;
        ready_o = 1'b1;
        last_o  = 1'b0;
      end
    endcase
  end

  assign data_o = data_i;
  assign len_o  = len_r;
  assign beat_o = beat_r;
  assign idle_o = (state_r == eHDR);

endmodule

// File: tb/tb_bsg_stream_len_framer.sv
// tb/tb_bsg_stream_len_framer.sv - randomized scoreboard bench for bsg_stream_len_framer

module tb_bsg_stream_len_framer;

  localparam int W  = 16;
  localparam int LW = 4;
  localparam int LO = 3;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [W-1:0]  data_i = '0;
  logic          v_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  data_o;
  logic          v_o;
  logic          ready_i = 1'b1;
  logic          last_o;
  logic [LW-1:0] len_o;
  logic [LW-1:0] beat_o;
  logic          idle_o;

  bsg_stream_len_framer #(.width_p(W), .len_width_p(LW), .len_offset_p(LO)) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .last_o(last_o),
    .len_o(len_o), .beat_o(beat_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the input word list annotated with what each word means.
  logic [W-1:0]  in_word[$];
  bit            in_hdr[$];
  bit            in_last[$];
  int            in_beat[$];
  int            in_len[$];
  logic [W-1:0]  exp_out[$];
  int            exp_nlast;
  int            prev_len = 0;

  logic [W-1:0]  got_out[$];
  int            got_nlast;
  int            ptr;
  int            pat_idx;

  task automatic new_list();
    in_word.delete(); in_hdr.delete(); in_last.delete();
    in_beat.delete(); in_len.delete(); exp_out.delete();
    exp_nlast = 0;
  endtask

  // Packet of length n, of which only nsend payload words are queued.
  task automatic add_pkt(input int n, input int nsend);
    logic [W-1:0] w;
    w = W'($urandom);
    w[LO +: LW] = LW'(n);
    in_word.push_back(w); in_hdr.push_back(1'b1); in_beat.push_back(0);
    in_len.push_back(prev_len);
`ifdef BSG_STREAM_LEN_FRAMER_FWD_HDR_EN
    in_last.push_back(n == 0);
    exp_out.push_back(w);
    if (n == 0) exp_nlast++;
`else
    in_last.push_back(1'b0);
`endif
    prev_len = n;
    for (int i = 0; i < nsend; i++) begin
      w = W'($urandom);
      in_word.push_back(w); in_hdr.push_back(1'b0); in_beat.push_back(i);
      in_len.push_back(n); in_last.push_back(i == n - 1);
      exp_out.push_back(w);
      if (i == n - 1) exp_nlast++;
    end
  endtask

  // One clock: drive after the edge, check and advance at the falling edge.
  task automatic step(input int mode);
    bit v, r, hdr, ev, er;
    @(posedge clk); #1;
    case (mode)
      0:       begin v = 1'b1; r = 1'b1; end
      1:       begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0); end
      default: begin v = 1'b1; r = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); end
    endcase
    pat_idx++;
    ready_i = r;
    if (ptr < in_word.size()) begin
      v_i = v; data_i = in_word[ptr];
    end else begin
      v_i = 1'b0; data_i = W'($urandom);
    end
    @(negedge clk);
    if (ptr < in_word.size()) begin
      hdr = in_hdr[ptr];
`ifdef BSG_STREAM_LEN_FRAMER_FWD_HDR_EN
      ev = v_i; er = ready_i;
`else
      ev = hdr ? 1'b0 : v_i; er = hdr ? 1'b1 : ready_i;
`endif
      check("idle", idle_o, hdr);
      check("ready", ready_o, er);
      check("valid", v_o, ev);
      check("len", len_o, in_len[ptr]);
      check("beat", beat_o, in_beat[ptr]);
      if (ev) begin
        check("data", data_o, in_word[ptr]);
        check("last", last_o, in_last[ptr]);
      end
      if (v_o && ready_i) begin
        got_out.push_back(data_o);
        if (last_o) got_nlast++;
      end
      if (v_i && ready_o) ptr++;
    end
  endtask

  task automatic run(input string tag, input int mode);
    int budget;
    ptr = 0; pat_idx = 0; got_out.delete(); got_nlast = 0;
    budget = in_word.size() * 20 + 100;
    while (ptr < in_word.size() && budget > 0) begin
      step(mode);
      budget--;
    end
    check({tag, "_timeout"}, (budget == 0), 0);
    check({tag, "_nbeats"}, got_out.size(), exp_out.size());
    check({tag, "_nlast"}, got_nlast, exp_nlast);
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
      if (got_out[i] !== exp_out[i]) check({tag, "_order"}, got_out[i], exp_out[i]);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1; v_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    check(tag, idle_o, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset_i = 1'b0;
    @(negedge clk);
    prev_len = 0;
    check("rst_v", v_o, 1'b0);
    check("rst_last", last_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_idle", idle_o, 1'b1);
    check("rst_len", len_o, 0);
    check("rst_beat", beat_o, 0);
  endtask

  initial begin
    do_reset();

    new_list(); add_pkt(3, 3); run("n3", 0); idle_cycle("n3_idle_after");

    new_list(); add_pkt(0, 0); add_pkt(1, 1); run("n0n1", 0); idle_cycle("n0n1_idle");

    new_list(); add_pkt(2, 2); run("stall", 2);

    new_list(); add_pkt(15, 15); run("n15", 0); idle_cycle("n15_idle");

    // Abandon an N=5 packet after two payload beats.
    new_list(); add_pkt(5, 2); run("part", 0);
    do_reset();
    new_list(); add_pkt(1, 1); run("after_rst", 0); idle_cycle("after_rst_idle");
    check("after_rst_len", len_o, 1);

    new_list();
    for (int p = 0; p < 1000; p++) begin
      int n;
      n = $urandom_range(0, 15);
      add_pkt(n, n);
    end
    run("rand", 1);
    idle_cycle("rand_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
